reg_bank: RTL and testbench

Parametrised register bank for the RISC_SPM datapath, generalising the single-bit load-enabled flip-flop to DEPTH registers of WIDTH bits. One registered write/modify port applies an operation (load, clear, increment, decrement, shift, rotate) to the addressed register; two read ports see the bank combinationally with optional write-forwarding. Zero and carry flags from the last executed operation are registered for the control unit.

---
 rtl/reg_bank_pkg.sv | 22 ++
 rtl/reg_bank_alu.sv | 49 ++++
 rtl/reg_bank.sv | 85 ++++++++
 tb/tb_reg_bank.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Op-code definitions for the RISC_SPM register bank, shared with the control-unit decoder.
package reg_bank_pkg;

  typedef logic [2:0] op_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_CLR  = 3'b010,
    OP_INC  = 3'b011,
    OP_DEC  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_ROL  = 3'b111
  } op_e;

  // True for every op code that modifies the addressed register.
  function automatic logic op_writes(input op_t op);
    return op != OP_NOP;
  endfunction

endpackage

// File: rtl/reg_bank_alu.sv
// Combinational modify unit: next register value and carry for one op; no latency, no flow control.
// Carry is the INC carry-out, DEC borrow, or the bit shifted out of SHL/SHR/ROL.
module reg_bank_alu
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] nxt,
  output logic             carry
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;

  // One extra bit captures carry-out on INC and borrow on DEC (0 - 1 sets the top bit).
  assign sum = {1'b0, cur} + {{WIDTH{1'b0}}, 1'b1};
  assign dif = {1'b0, cur} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    nxt   = cur;
    carry = 1'b0;
    case (op_e'(op))
      OP_LOAD: nxt = data_in;
      OP_CLR:  nxt = '0;
      OP_INC:  {carry, nxt} = sum;
      OP_DEC:  {carry, nxt} = dif;
      OP_SHL: begin
        nxt   = {cur[WIDTH-2:0], 1'b0};
        carry = cur[WIDTH-1];
      end
      OP_SHR: begin
        nxt   = {1'b0, cur[WIDTH-1:1]};
        carry = cur[0];
      end
      OP_ROL: begin
        nxt   = {cur[WIDTH-2:0], cur[WIDTH-1]};
        carry = cur[WIDTH-1];
      end
      default: begin
        nxt   = cur;
        carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reg_bank.sv
// DEPTH x WIDTH register bank with one registered modify port, two combinational read ports and zero/carry flags.
// Writes land on the clk edge; with BYPASS=1 reads forward the pending result in the same cycle.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  op_t              op,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  output logic             zero_flag,
  output logic             carry_flag
);

  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic [WIDTH-1:0] bank [DEPTH];
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] stored_a;
  logic [WIDTH-1:0] stored_b;
  logic [WIDTH-1:0] alu_nxt;
  logic             alu_carry;
  logic             wr_in_range;
  logic             exec;
  logic             fwd_a;
  logic             fwd_b;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);

  // Gating with rst keeps an op that collides with reset from forwarding onto the read ports.
  assign exec = rst && load && op_writes(op) && wr_in_range;

  // Address decode by comparison so non-power-of-two depths read 0 above the top register.
  always_comb begin
    cur      = '0;
    stored_a = '0;
    stored_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_addr == AW'(i)) cur = bank[i];
      if (rd_addr_a == AW'(i)) stored_a = bank[i];
      if (rd_addr_b == AW'(i)) stored_b = bank[i];
    end
  end

  reg_bank_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op     (op),
    .cur    (cur),
    .data_in(data_in),
    .nxt    (alu_nxt),
    .carry  (alu_carry)
  );

  assign fwd_a = (BYPASS != 0) && exec && (rd_addr_a == wr_addr);
  assign fwd_b = (BYPASS != 0) && exec && (rd_addr_b == wr_addr);

  assign data_out_a = fwd_a ? alu_nxt : stored_a;
  assign data_out_b = fwd_b ? alu_nxt : stored_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else if (exec) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_addr == AW'(i)) bank[i] <= alu_nxt;
      end
      zero_flag  <= (alu_nxt == '0);
      carry_flag <= alu_carry;
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: bypass, stored-only and three-register instances share one stimulus stream.
module tb_reg_bank;
  import reg_bank_pkg::*;

  logic       clk;
  logic       rst;
  logic       load;
  logic [2:0] op;
  logic [1:0] wr_addr;
  logic [7:0] data_in;
  logic [1:0] rd_addr_a;
  logic [1:0] rd_addr_b;

  logic [7:0] a_by, b_by, a_nb, b_nb, a_d3, b_d3;
  logic       z_by, c_by, z_nb, c_nb, z_d3, c_d3;

  int total = 0;
  int bad   = 0;

  reg_bank #(.WIDTH(8), .DEPTH(4), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .load(load), .op(op), .wr_addr(wr_addr), .data_in(data_in),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .data_out_a(a_by), .data_out_b(b_by),
    .zero_flag(z_by), .carry_flag(c_by));

  reg_bank #(.WIDTH(8), .DEPTH(4), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .load(load), .op(op), .wr_addr(wr_addr), .data_in(data_in),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .data_out_a(a_nb), .data_out_b(b_nb),
    .zero_flag(z_nb), .carry_flag(c_nb));

  reg_bank #(.WIDTH(8), .DEPTH(3), .BYPASS(1)) dut_d3 (
    .clk(clk), .rst(rst), .load(load), .op(op), .wr_addr(wr_addr), .data_in(data_in),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .data_out_a(a_d3), .data_out_b(b_d3),
    .zero_flag(z_d3), .carry_flag(c_d3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [2:0] op;
    logic [1:0] wa;
    logic [7:0] din;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] pa;   // port A before the edge, bypass instance
    logic [7:0] pb;   // port B before the edge, bypass instance
    logic [7:0] pna;  // port A before the edge, stored-only instance
    logic [7:0] a;    // port A after the edge (both instances)
    logic [7:0] b;    // port B after the edge (both instances)
    logic       z;
    logic       c;
  } vec_t;

  vec_t vt[17];
  vec_t sbq[$];

  function automatic vec_t mk(input logic ld, input logic [2:0] o, input logic [1:0] wa,
                              input logic [7:0] din, input logic [1:0] ra, input logic [1:0] rb,
                              input logic [7:0] pa, input logic [7:0] pb, input logic [7:0] pna,
                              input logic [7:0] a, input logic [7:0] b, input logic z, input logic c);
    vec_t v;
    v.ld = ld; v.op = o; v.wa = wa; v.din = din; v.ra = ra; v.rb = rb;
    v.pa = pa; v.pb = pb; v.pna = pna; v.a = a; v.b = b; v.z = z; v.c = c;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ld, input logic [2:0] o, input logic [1:0] wa,
                       input logic [7:0] din, input logic [1:0] ra, input logic [1:0] rb);
    load = ld; op = o; wr_addr = wa; data_in = din; rd_addr_a = ra; rd_addr_b = rb;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vt[0]  = mk(1, OP_LOAD, 2, 8'hA5, 2, 1, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00, 0, 0);
    vt[1]  = mk(1, OP_LOAD, 0, 8'hFF, 0, 2, 8'hFF, 8'hA5, 8'h00, 8'hFF, 8'hA5, 0, 0);
    vt[2]  = mk(1, OP_INC,  0, 8'h00, 0, 0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 1, 1);
    vt[3]  = mk(1, OP_DEC,  0, 8'h00, 0, 2, 8'hFF, 8'hA5, 8'h00, 8'hFF, 8'hA5, 0, 1);
    vt[4]  = mk(1, OP_LOAD, 3, 8'h81, 3, 0, 8'h81, 8'hFF, 8'h00, 8'h81, 8'hFF, 0, 0);
    vt[5]  = mk(1, OP_SHL,  3, 8'h00, 3, 3, 8'h02, 8'h02, 8'h81, 8'h02, 8'h02, 0, 1);
    vt[6]  = mk(1, OP_SHR,  3, 8'h00, 3, 3, 8'h01, 8'h01, 8'h02, 8'h01, 8'h01, 0, 0);
    vt[7]  = mk(1, OP_LOAD, 3, 8'h81, 3, 2, 8'h81, 8'hA5, 8'h01, 8'h81, 8'hA5, 0, 0);
    vt[8]  = mk(1, OP_ROL,  3, 8'h00, 3, 0, 8'h03, 8'hFF, 8'h81, 8'h03, 8'hFF, 0, 1);
    vt[9]  = mk(0, OP_LOAD, 3, 8'h00, 3, 0, 8'h03, 8'hFF, 8'h03, 8'h03, 8'hFF, 0, 1);
    vt[10] = mk(1, OP_NOP,  3, 8'h00, 3, 0, 8'h03, 8'hFF, 8'h03, 8'h03, 8'hFF, 0, 1);
    vt[11] = mk(1, OP_CLR,  2, 8'h00, 2, 3, 8'h00, 8'h03, 8'hA5, 8'h00, 8'h03, 1, 0);
    vt[12] = mk(1, OP_SHR,  0, 8'h00, 0, 1, 8'h7F, 8'h00, 8'hFF, 8'h7F, 8'h00, 0, 1);
    vt[13] = mk(1, OP_SHL,  1, 8'h00, 1, 0, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h7F, 1, 0);
    vt[14] = mk(1, OP_ROL,  0, 8'h00, 0, 0, 8'hFE, 8'hFE, 8'h7F, 8'hFE, 8'hFE, 0, 0);
    vt[15] = mk(1, OP_DEC,  1, 8'h00, 1, 3, 8'hFF, 8'h03, 8'h00, 8'hFF, 8'h03, 0, 1);
    vt[16] = mk(1, OP_INC,  1, 8'h00, 1, 1, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 1, 1);

    // Reset asserted before the first clock edge; a LOAD held during reset must be lost.
    rst = 1'b1;
    drive(1, OP_LOAD, 2, 8'hA5, 2, 1);
    #1 rst = 1'b0;
    #2;
    chk("reset_a", a_by, 8'h00);
    chk("reset_b", b_by, 8'h00);
    chk("reset_zero", {7'b0, z_by}, 8'h00);
    chk("reset_carry", {7'b0, c_by}, 8'h00);
    @(posedge clk); #1;
    chk("reset_load_lost", a_nb, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    drive(0, OP_NOP, 0, 8'h00, 0, 0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vt[i].ld, vt[i].op, vt[i].wa, vt[i].din, vt[i].ra, vt[i].rb);
      sbq.push_back(vt[i]);
      #1;
      chk($sformatf("v%0d_pre_a_bypass", i), a_by, vt[i].pa);
      chk($sformatf("v%0d_pre_b_bypass", i), b_by, vt[i].pb);
      chk($sformatf("v%0d_pre_a_stored", i), a_nb, vt[i].pna);
      @(posedge clk); #1;
      v = sbq.pop_front();
      chk($sformatf("v%0d_a", i), a_nb, v.a);
      chk($sformatf("v%0d_b", i), b_nb, v.b);
      chk($sformatf("v%0d_zero", i), {7'b0, z_nb}, {7'b0, v.z});
      chk($sformatf("v%0d_carry", i), {7'b0, c_nb}, {7'b0, v.c});
      chk($sformatf("v%0d_zero_bypass_inst", i), {7'b0, z_by}, {7'b0, v.z});
    end

    // Mid-cycle reset with a LOAD pending: bank and flags clear with no clock edge.
    @(negedge clk);
    drive(1, OP_LOAD, 0, 8'h55, 0, 3);
    #2 rst = 1'b0;
    #1;
    chk("midreset_a", a_by, 8'h00);
    chk("midreset_b", b_by, 8'h00);
    chk("midreset_zero", {7'b0, z_by}, 8'h00);
    chk("midreset_carry", {7'b0, c_by}, 8'h00);
    @(posedge clk); #1;
    chk("midreset_load_lost", a_nb, 8'h00);

    // Streaming INC: consecutive ops accumulate, reset mid-stream, first INC after release gives 1.
    @(negedge clk);
    drive(1, OP_INC, 0, 8'h00, 0, 0);
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stream_inc%0d", k), a_nb, 8'(k));
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("stream_reset_stored", a_nb, 8'h00);
    chk("stream_reset_bypass", a_by, 8'h00);
    @(posedge clk); #1;
    chk("stream_reset_hold", a_nb, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("stream_first_inc", a_nb, 8'h01);
    chk("stream_first_zero", {7'b0, z_nb}, 8'h00);

    // DEPTH=3: a write to address 3 is ignored, flags hold, and address 3 reads 0.
    @(negedge clk);
    drive(1, OP_LOAD, 1, 8'hFF, 3, 1);
    @(posedge clk); #1;
    chk("d3_load_r1", b_d3, 8'hFF);
    chk("d3_load_zero", {7'b0, z_d3}, 8'h00);
    @(negedge clk);
    drive(1, OP_LOAD, 3, 8'h00, 3, 1);
    #1;
    chk("d3_oor_pre_a", a_d3, 8'h00);
    @(posedge clk); #1;
    chk("d3_oor_zero_hold", {7'b0, z_d3}, 8'h00);
    chk("d3_oor_carry_hold", {7'b0, c_d3}, 8'h00);
    chk("d3_oor_read", a_d3, 8'h00);
    chk("d3_r1_kept", b_d3, 8'hFF);
    chk("d4_r3_zero", {7'b0, z_by}, 8'h01);
    @(negedge clk);
    drive(0, OP_NOP, 0, 8'h00, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
